// File: rtl/register_unit_n_pkg.sv
// Shared types for the parametrised X/A/B register unit of the shift-add multiplier.
package register_unit_n_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_HOLD       = 3'd0,
        OP_LOAD_B     = 3'd1,
        OP_CLEAR_XA   = 3'd2,
        OP_LOAD_XA    = 3'd3,
        OP_SHIFT      = 3'd4,
        OP_LOAD_SHIFT = 3'd5,
        OP_CLEAR_ALL  = 3'd6
    } op_t;

endpackage

// File: rtl/reg_n.sv
// WIDTH-bit register with parallel load and right shift; MSB filled from Shift_In.
module reg_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Shift_En,
    input  logic             Shift_In,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out
);

    // Load wins over shift so the top can express fused load-and-shift as a plain load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_Out <= '0;
        end else if (Load) begin
            Data_Out <= D;
        end else if (Shift_En) begin
            Data_Out <= {Shift_In, Data_Out[WIDTH-1:1]};
        end
    end

    assign Shift_Out = Data_Out[0];

endmodule

// File: rtl/register_unit_n.sv
// X/A/B datapath register unit with opcode decode, saturating shift counter and error flag.
module register_unit_n
    import register_unit_n_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  op_t              Op,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH:0]   Sum,
    output logic             X,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             M,
    output logic [CNT_W-1:0] Shift_Cnt,
    output logic             Done,
    output logic             Shift_Err
);

    logic             a_load;
    logic [WIDTH-1:0] a_d;
    logic             a_shift;
    logic             a_shift_out;
    logic             b_load;
    logic             b_shift;
    logic             b_shift_in;
    logic             b_shift_out;
    logic             x_next;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;

    assign Done = (Shift_Cnt == CNT_W'(WIDTH));
    assign M    = b_shift_out;

    // Opcode decode; a shift request at full count is swallowed and flagged.
    always_comb begin
        a_load     = 1'b0;
        a_d        = '0;
        a_shift    = 1'b0;
        b_load     = 1'b0;
        b_shift    = 1'b0;
        b_shift_in = a_shift_out;
        x_next     = X;
        cnt_next   = Shift_Cnt;
        err_next   = Shift_Err;
        case (Op)
            OP_LOAD_B: begin
                b_load = 1'b1;
            end
            OP_CLEAR_XA: begin
                a_load   = 1'b1;
                x_next   = 1'b0;
                cnt_next = '0;
                err_next = 1'b0;
            end
            OP_LOAD_XA: begin
                a_load = 1'b1;
                a_d    = Sum[WIDTH-1:0];
                x_next = Sum[WIDTH];
            end
            OP_SHIFT: begin
                if (Done) begin
                    err_next = 1'b1;
                end else begin
                    a_shift  = 1'b1;
                    b_shift  = 1'b1;
                    cnt_next = Shift_Cnt + CNT_W'(1);
                end
            end
            OP_LOAD_SHIFT: begin
                if (Done) begin
                    err_next = 1'b1;
                end else begin
                    a_load     = 1'b1;
                    a_d        = {Sum[WIDTH], Sum[WIDTH-1:1]};
                    x_next     = Sum[WIDTH];
                    b_shift    = 1'b1;
                    b_shift_in = Sum[0];
                    cnt_next   = Shift_Cnt + CNT_W'(1);
                end
            end
            OP_CLEAR_ALL: begin
                a_load   = 1'b1;
                b_load   = 1'b1;
                x_next   = 1'b0;
                cnt_next = '0;
                err_next = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // X, counter and sticky error state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            X         <= 1'b0;
            Shift_Cnt <= '0;
            Shift_Err <= 1'b0;
        end else begin
            X         <= x_next;
            Shift_Cnt <= cnt_next;
            Shift_Err <= err_next;
        end
    end

    reg_n #(.WIDTH(WIDTH)) u_reg_a (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (a_load),
        .Shift_En  (a_shift),
        .Shift_In  (X),
        .D         (a_d),
        .Data_Out  (A),
        .Shift_Out (a_shift_out)
    );

    reg_n #(.WIDTH(WIDTH)) u_reg_b (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (b_load),
        .Shift_En  (b_shift),
        .Shift_In  (b_shift_in),
        .D         (D),
        .Data_Out  (B),
        .Shift_Out (b_shift_out)
    );

endmodule

// File: tb/tb_register_unit_n.sv
// Directed bench for register_unit_n at WIDTH=8 and WIDTH=16.
module tb_register_unit_n;
    import register_unit_n_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst8 = 1'b1;
    op_t         op8  = OP_HOLD;
    logic [7:0]  d8   = '0;
    logic [8:0]  sum8 = '0;
    logic        x8, m8, done8, err8;
    logic [7:0]  a8, b8;
    logic [3:0]  cnt8;

    logic        rst16 = 1'b1;
    op_t         op16  = OP_HOLD;
    logic [15:0] d16   = '0;
    logic [16:0] sum16 = '0;
    logic        x16, m16, done16, err16;
    logic [15:0] a16, b16;
    logic [4:0]  cnt16;

    register_unit_n #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst8), .Op(op8), .D(d8), .Sum(sum8),
        .X(x8), .A(a8), .B(b8), .M(m8), .Shift_Cnt(cnt8), .Done(done8), .Shift_Err(err8)
    );

    register_unit_n #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst16), .Op(op16), .D(d16), .Sum(sum16),
        .X(x16), .A(a16), .B(b16), .M(m16), .Shift_Cnt(cnt16), .Done(done16), .Shift_Err(err16)
    );

    task automatic cyc8(input logic rst, input op_t op, input logic [7:0] d, input logic [8:0] s);
        rst8 = rst; op8 = op; d8 = d; sum8 = s;
        @(posedge clk); #1;
    endtask

    task automatic cyc16(input logic rst, input op_t op, input logic [15:0] d, input logic [16:0] s);
        rst16 = rst; op16 = op; d16 = d; sum16 = s;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        cyc8(1'b1, OP_HOLD, 8'h00, 9'h000);
        checks++;
        if ({x8, a8, b8, m8, cnt8, done8, err8} !== 24'h0) begin
            errors++;
            $display("FAIL reset8 got x=%b a=%h b=%h m=%b cnt=%0d done=%b err=%b want all 0",
                     x8, a8, b8, m8, cnt8, done8, err8);
        end
        cyc8(1'b0, OP_CLEAR_ALL, 8'h07, 9'h000);
        checks++;
        if (x8 !== 1'b0 || a8 !== 8'h00 || b8 !== 8'h07 || m8 !== 1'b1 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL clear_all8 got x=%b a=%h b=%h m=%b cnt=%0d done=%b want 0 00 07 1 0 0",
                     x8, a8, b8, m8, cnt8, done8);
        end
    endtask

    task automatic test_load_shift_sep;
        cyc8(1'b0, OP_LOAD_XA, 8'h00, 9'h1C5);
        checks++;
        if (x8 !== 1'b1 || a8 !== 8'hC5 || b8 !== 8'h07 || cnt8 !== 4'd0) begin
            errors++;
            $display("FAIL load_xa got x=%b a=%h b=%h cnt=%0d want 1 c5 07 0", x8, a8, b8, cnt8);
        end
        cyc8(1'b0, OP_SHIFT, 8'h00, 9'h000);
        checks++;
        if (x8 !== 1'b1 || a8 !== 8'hE2 || b8 !== 8'h83 || cnt8 !== 4'd1 || m8 !== 1'b1) begin
            errors++;
            $display("FAIL shift got x=%b a=%h b=%h cnt=%0d m=%b want 1 e2 83 1 1", x8, a8, b8, cnt8, m8);
        end
        cyc8(1'b0, OP_LOAD_B, 8'h5A, 9'h000);
        checks++;
        if (x8 !== 1'b1 || a8 !== 8'hE2 || b8 !== 8'h5A || cnt8 !== 4'd1 || m8 !== 1'b0) begin
            errors++;
            $display("FAIL load_b got x=%b a=%h b=%h cnt=%0d m=%b want 1 e2 5a 1 0", x8, a8, b8, cnt8, m8);
        end
        cyc8(1'b0, OP_HOLD, 8'hFF, 9'h1FF);
        checks++;
        if (x8 !== 1'b1 || a8 !== 8'hE2 || b8 !== 8'h5A || cnt8 !== 4'd1) begin
            errors++;
            $display("FAIL hold got x=%b a=%h b=%h cnt=%0d want 1 e2 5a 1", x8, a8, b8, cnt8);
        end
    endtask

    task automatic test_fused;
        cyc8(1'b0, OP_CLEAR_ALL, 8'h07, 9'h000);
        cyc8(1'b0, OP_LOAD_SHIFT, 8'h00, 9'h003);
        checks++;
        if (x8 !== 1'b0 || a8 !== 8'h01 || b8 !== 8'h83 || cnt8 !== 4'd1) begin
            errors++;
            $display("FAIL load_shift got x=%b a=%h b=%h cnt=%0d want 0 01 83 1", x8, a8, b8, cnt8);
        end
    endtask

    // -3 * -5: adder sums precomputed by hand for each multiplier bit.
    task automatic test_multiply;
        op_t        ops  [8];
        logic [8:0] sums [8];
        ops  = '{OP_LOAD_SHIFT, OP_SHIFT, OP_LOAD_SHIFT, OP_LOAD_SHIFT,
                 OP_LOAD_SHIFT, OP_LOAD_SHIFT, OP_LOAD_SHIFT, OP_LOAD_SHIFT};
        sums = '{9'h1FB, 9'h000, 9'h1F9, 9'h1F7, 9'h1F6, 9'h1F6, 9'h1F6, 9'h000};
        cyc8(1'b0, OP_CLEAR_ALL, 8'hFD, 9'h000);
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b0, ops[i], 8'h00, sums[i]);
            if (i == 0) begin
                checks++;
                if (x8 !== 1'b1 || a8 !== 8'hFD || b8 !== 8'hFE) begin
                    errors++;
                    $display("FAIL mul_step1 got x=%b a=%h b=%h want 1 fd fe", x8, a8, b8);
                end
            end
            if (i == 6) begin
                checks++;
                if (done8 !== 1'b0 || cnt8 !== 4'd7) begin
                    errors++;
                    $display("FAIL mul_cnt7 got cnt=%0d done=%b want 7 0", cnt8, done8);
                end
            end
        end
        checks++;
        if ({a8, b8} !== 16'h000F || x8 !== 1'b0 || done8 !== 1'b1 || cnt8 !== 4'd8 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL mul_result got x=%b ab=%h cnt=%0d done=%b err=%b want 0 000f 8 1 0",
                     x8, {a8, b8}, cnt8, done8, err8);
        end
    endtask

    task automatic test_saturate;
        cyc8(1'b0, OP_SHIFT, 8'h00, 9'h000);
        checks++;
        if (x8 !== 1'b0 || {a8, b8} !== 16'h000F || cnt8 !== 4'd8 || err8 !== 1'b1 || done8 !== 1'b1) begin
            errors++;
            $display("FAIL sat_shift got x=%b ab=%h cnt=%0d err=%b done=%b want 0 000f 8 1 1",
                     x8, {a8, b8}, cnt8, err8, done8);
        end
        cyc8(1'b0, OP_LOAD_SHIFT, 8'h00, 9'h1AB);
        checks++;
        if (x8 !== 1'b0 || {a8, b8} !== 16'h000F || cnt8 !== 4'd8 || err8 !== 1'b1) begin
            errors++;
            $display("FAIL sat_load_shift got x=%b ab=%h cnt=%0d err=%b want 0 000f 8 1",
                     x8, {a8, b8}, cnt8, err8);
        end
        cyc8(1'b0, OP_LOAD_XA, 8'h00, 9'h011);
        checks++;
        if (err8 !== 1'b1 || a8 !== 8'h11) begin
            errors++;
            $display("FAIL err_sticky got err=%b a=%h want 1 11", err8, a8);
        end
        cyc8(1'b0, OP_CLEAR_XA, 8'h00, 9'h000);
        checks++;
        if (err8 !== 1'b0 || cnt8 !== 4'd0 || b8 !== 8'h0F || a8 !== 8'h00 || x8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL clear_xa got x=%b a=%h b=%h cnt=%0d err=%b done=%b want 0 00 0f 0 0 0",
                     x8, a8, b8, cnt8, err8, done8);
        end
    endtask

    task automatic test_mid_reset;
        cyc8(1'b0, OP_CLEAR_ALL, 8'h07, 9'h000);
        for (int i = 0; i < 3; i++) cyc8(1'b0, OP_SHIFT, 8'h00, 9'h000);
        checks++;
        if (cnt8 !== 4'd3) begin
            errors++;
            $display("FAIL mid_cnt got cnt=%0d want 3", cnt8);
        end
        cyc8(1'b1, OP_LOAD_SHIFT, 8'h55, 9'h1FF);
        checks++;
        if ({x8, a8, b8, m8, cnt8, done8, err8} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset got x=%b a=%h b=%h m=%b cnt=%0d done=%b err=%b want all 0",
                     x8, a8, b8, m8, cnt8, done8, err8);
        end
        rst8 = 1'b0;
    endtask

    task automatic test_width16;
        cyc16(1'b1, OP_HOLD, 16'h0, 17'h0);
        checks++;
        if ({x16, a16, b16, cnt16, done16, err16} !== 40'h0) begin
            errors++;
            $display("FAIL reset16 got x=%b a=%h b=%h cnt=%0d done=%b err=%b want all 0",
                     x16, a16, b16, cnt16, done16, err16);
        end
        cyc16(1'b0, OP_CLEAR_ALL, 16'h0007, 17'h0);
        cyc16(1'b0, OP_LOAD_XA, 16'h0, 17'h180C5);
        checks++;
        if (x16 !== 1'b1 || a16 !== 16'h80C5 || b16 !== 16'h0007 || m16 !== 1'b1) begin
            errors++;
            $display("FAIL load_xa16 got x=%b a=%h b=%h m=%b want 1 80c5 0007 1", x16, a16, b16, m16);
        end
        cyc16(1'b0, OP_SHIFT, 16'h0, 17'h0);
        checks++;
        if (x16 !== 1'b1 || a16 !== 16'hC062 || b16 !== 16'h8003 || cnt16 !== 5'd1) begin
            errors++;
            $display("FAIL shift16 got x=%b a=%h b=%h cnt=%0d want 1 c062 8003 1", x16, a16, b16, cnt16);
        end
        for (int i = 0; i < 14; i++) cyc16(1'b0, OP_SHIFT, 16'h0, 17'h0);
        checks++;
        if (cnt16 !== 5'd15 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL cnt15_16 got cnt=%0d done=%b want 15 0", cnt16, done16);
        end
        cyc16(1'b0, OP_LOAD_SHIFT, 16'h0, 17'h00003);
        checks++;
        if (cnt16 !== 5'd16 || done16 !== 1'b1 || err16 !== 1'b0 || a16 !== 16'h0001 || x16 !== 1'b0) begin
            errors++;
            $display("FAIL done16 got cnt=%0d done=%b err=%b a=%h x=%b want 16 1 0 0001 0",
                     cnt16, done16, err16, a16, x16);
        end
        cyc16(1'b0, OP_SHIFT, 16'h0, 17'h0);
        checks++;
        if (cnt16 !== 5'd16 || err16 !== 1'b1 || a16 !== 16'h0001 || x16 !== 1'b0) begin
            errors++;
            $display("FAIL sat16 got cnt=%0d err=%b a=%h x=%b want 16 1 0001 0", cnt16, err16, a16, x16);
        end
        cyc16(1'b0, OP_CLEAR_ALL, 16'hBEEF, 17'h0);
        checks++;
        if (cnt16 !== 5'd0 || err16 !== 1'b0 || b16 !== 16'hBEEF || a16 !== 16'h0 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL clear_all16 got cnt=%0d err=%b b=%h a=%h done=%b want 0 0 beef 0000 0",
                     cnt16, err16, b16, a16, done16);
        end
    endtask

    initial begin
        test_reset();
        test_load_shift_sep();
        test_fused();
        test_multiply();
        test_saturate();
        test_mid_reset();
        test_width16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
